muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands and produces a writeback value, a destination register index and a write strobe that drive the register file's Write_data / Rd / RegWrite inputs.
- Multi-cycle, with a start/busy/done handshake, so the pipeline stalls on busy.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must hold values 0..XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  request; sampled only in IDLE
- Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Read_data1  input  32  operand A (rs1 value)
- Read_data2  input  32  operand B (rs2 value)
- Rd_in  input  5  destination register of the request
- Busy  output  1  high whenever state is not IDLE
- Write_data  output  32  result; held stable from done until the next accepted Start
- Rd  output  5  captured Rd_in
- RegWrite  output  1  one-cycle write strobe (equals done); forced 0 if the captured Rd is 0

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, internal registers 0.
  - Asynchronous: takes effect immediately, including mid-operation.
  - An operation in flight is discarded and never produces RegWrite.
- States and transitions:
  - IDLE: when Start=1 at edge E0, capture Funct3, Rd_in and both operands.
    - For signed ops, store absolute values and the result sign.
    - Go to CALC with counter 0.
  - CALC: perform one radix-2 step per edge and increment the counter.
    - After the 32nd step (edge E32), go to DONE and latch the final result into Write_data.
  - DONE: RegWrite=1 for exactly this one cycle; next edge goes to IDLE.
  - Nominal latency: Start at E0, RegWrite high in the cycle after E32, Busy low again after E33.
- Start while Busy=1 is ignored (no queueing). Inputs are not required to stay stable after E0.
- Multiply: unsigned shift-add on |A| and |B| into a 64-bit product, then apply the sign.
  - Signedness: MULH signs both operands, MULHSU signs A only, MULHU neither.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
- Divide: restoring shift-subtract on magnitudes.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Divide by zero (B=0), detected at E0:
  - Skip CALC and go directly to DONE at E1.
  - DIV/DIVU return 0xFFFFFFFF; REM/REMU return A.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM), detected at E0:
  - Go directly to DONE at E1.
  - DIV returns 0x80000000; REM returns 0.
- Rd=0: the operation completes normally, Write_data is updated, RegWrite stays 0.
- Start asserted on the same edge the unit leaves DONE (i.e. while still Busy) is ignored; Start is accepted only on the edge after Busy falls.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply ops (Funct3[2]=0) use a combinational 64-bit multiplier, go IDLE→DONE at E0, and raise RegWrite in the cycle after E0. Divide ops are unchanged.
- Undefined: multiplies use the 32-step iterative path; no `*` operator is synthesised.

Test Plan:
- MUL: A=7, B=6, Rd_in=5, Start for one cycle -> Busy for 33 cycles; RegWrite pulses once with Write_data=42, Rd=5. With MULDIV_FAST_MUL_EN, RegWrite comes in the cycle after E0.
- MULH/MULHSU/MULHU with A=0xFFFFFFFF (-1), B=2 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001 respectively; MUL gives 0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). DIVU A=20, B=3 -> 6. REMU -> 2.
- Corner cases, each completing with RegWrite in the cycle after E1:
  - DIV A=5, B=0 -> 0xFFFFFFFF.
  - REM A=5, B=0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Handshake and Rd=0:
  - Second Start pulsed mid-CALC is ignored; exactly one RegWrite pulse is seen.
  - Operation with Rd_in=0 completes with Write_data updated and RegWrite=0.
- Reset asserted asynchronously at cycle 10 of a DIV -> Busy, RegWrite, Write_data and Rd go to 0 immediately without a clock edge; no RegWrite follows. A new Start after reset release behaves normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a start/busy/done handshake.
// Multiply uses radix-2 shift-add and divide uses restoring shift-subtract,
// one step per clock over 32 steps. Both work on operand magnitudes, and the
// result sign is applied when the result is latched.
// Optional build macro MULDIV_FAST_MUL_EN: when it is defined, multiplies use
// a single-cycle combinational multiplier. Divides always take the iterative path.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Read_data1,
  input  logic [XLEN-1:0] Read_data2,
  input  logic [4:0]      Rd_in,
  output logic            Busy,
  output logic [XLEN-1:0] Write_data,
  output logic [4:0]      Rd,
  output logic            RegWrite
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]   L_ONE   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] L_ONE2  = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   L_MINW  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0]  L_LAST  = CNT_W'(XLEN-1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic              r_spec;
  logic [XLEN-1:0]   r_m;       // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] r_acc;     // {partial product | remainder, multiplier | quotient}
  logic [XLEN-1:0]   r_wdata;
  logic              r_busy;
  logic              r_regwrite;

  // Request decode, evaluated on the operands that are present while IDLE.
  logic            w_is_div;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div0;
  logic            w_ovf;
  logic            w_spec;
  logic [XLEN-1:0] w_spec_val;
  logic            w_neg;
  logic            w_fast;
  logic [4:0]      w_wr_rd;

  assign w_is_div = Funct3[2];
  // rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for MULH, DIV and REM.
  assign w_sa = Read_data1[XLEN-1] & ((Funct3 == 3'b001) | (Funct3 == 3'b010) |
                                      (Funct3 == 3'b100) | (Funct3 == 3'b110));
  assign w_sb = Read_data2[XLEN-1] & ((Funct3 == 3'b001) | (Funct3 == 3'b100) |
                                      (Funct3 == 3'b110));
  assign w_abs_a = w_sa ? (~Read_data1 + L_ONE) : Read_data1;
  assign w_abs_b = w_sb ? (~Read_data2 + L_ONE) : Read_data2;
  assign w_div0  = w_is_div & (Read_data2 == {XLEN{1'b0}});
  assign w_ovf   = ((Funct3 == 3'b100) | (Funct3 == 3'b110)) &
                   (Read_data1 == L_MINW) & (Read_data2 == {XLEN{1'b1}});
  assign w_spec  = w_div0 | w_ovf;
  // Remainders take the sign of the dividend. All other results take the XOR of the operand signs.
  assign w_neg   = (w_is_div & Funct3[1]) ? w_sa : (w_sa ^ w_sb);

  // Fixed results for divide-by-zero and signed overflow.
  always_comb begin
    w_spec_val = {XLEN{1'b0}};
    if (w_div0) begin
      w_spec_val = Funct3[1] ? Read_data1 : {XLEN{1'b1}};
    end else if (w_ovf) begin
      w_spec_val = Funct3[1] ? {XLEN{1'b0}} : L_MINW;
    end else begin
      w_spec_val = {XLEN{1'b0}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a;
  logic [2*XLEN-1:0] w_fast_b;
  logic [2*XLEN-1:0] w_fast_p;
  logic [XLEN-1:0]   w_fast_val;
  // Sign-extend the operands to 64 bits. The low 64 bits of the product are then correct for all signedness combinations.
  assign w_fast_a   = {{XLEN{w_sa}}, Read_data1};
  assign w_fast_b   = {{XLEN{w_sb}}, Read_data2};
  assign w_fast_p   = w_fast_a * w_fast_b;
  assign w_fast_val = (Funct3[1:0] == 2'b00) ? w_fast_p[XLEN-1:0] : w_fast_p[2*XLEN-1:XLEN];
  assign w_fast     = ~Funct3[2];
`else
  assign w_fast     = 1'b0;
`endif

  // One iteration step. The multiply step is shift-add. The divide step is restoring shift-subtract.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_rem;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_step_next;
  logic [2*XLEN-1:0] w_prod_fin;
  logic [XLEN-1:0]   w_div_sel;
  logic [XLEN-1:0]   w_div_fin;
  logic [XLEN-1:0]   w_result;

  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
  assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
  // After a successful subtract the remainder is below the divisor, so 32 bits hold it.
  assign w_div_rem   = w_div_ge ? (w_div_shift[XLEN-1:0] - r_m) : w_div_shift[XLEN-1:0];
  assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};
  assign w_step_next = r_funct3[2] ? w_div_next : w_mul_next;

  assign w_prod_fin  = r_neg ? (~w_mul_next + L_ONE2) : w_mul_next;
  assign w_div_sel   = r_funct3[1] ? w_div_next[2*XLEN-1:XLEN] : w_div_next[XLEN-1:0];
  assign w_div_fin   = r_neg ? (~w_div_sel + L_ONE) : w_div_sel;

  // Result selection for the final iteration step.
  always_comb begin
    w_result = {XLEN{1'b0}};
    if (r_funct3[2]) begin
      w_result = w_div_fin;
    end else if (r_funct3[1:0] == 2'b00) begin
      w_result = w_prod_fin[XLEN-1:0];
    end else begin
      w_result = w_prod_fin[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic for the IDLE / CALC / DONE sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next = w_fast ? S_DONE : S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_spec || (r_cnt == L_LAST)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_CALC;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // In IDLE the write target is still on the input port. In every other state it is the captured index.
  assign w_wr_rd = (r_state == S_IDLE) ? Rd_in : r_rd;

  // State register and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_regwrite <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != S_IDLE);
      r_regwrite <= (w_next == S_DONE) && (w_wr_rd != 5'd0);
    end
  end

  // Datapath: capture the request, iterate, and latch the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_funct3 <= 3'b000;
      r_rd     <= 5'd0;
      r_neg    <= 1'b0;
      r_spec   <= 1'b0;
      r_m      <= {XLEN{1'b0}};
      r_acc    <= {(2*XLEN){1'b0}};
      r_wdata  <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_funct3 <= Funct3;
            r_rd     <= Rd_in;
            r_neg    <= w_neg;
            r_spec   <= w_spec;
            r_m      <= w_is_div ? w_abs_b : w_abs_a;
            r_acc    <= w_spec ? {{XLEN{1'b0}}, w_spec_val}
                               : {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
`ifdef MULDIV_FAST_MUL_EN
            if (w_fast) begin
              r_wdata <= w_fast_val;
            end
`endif
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          r_acc <= w_step_next;
          if (r_spec) begin
            r_wdata <= r_acc[XLEN-1:0];
          end else if (r_cnt == L_LAST) begin
            r_wdata <= w_result;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign Busy       = r_busy;
  assign Write_data = r_wdata;
  assign Rd         = r_rd;
  assign RegWrite   = r_regwrite;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [4:0]  Rd_in;
  logic        Busy;
  logic [31:0] Write_data;
  logic [4:0]  Rd;
  logic        RegWrite;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Funct3     (Funct3),
    .Read_data1 (Read_data1),
    .Read_data2 (Read_data2),
    .Rd_in      (Rd_in),
    .Busy       (Busy),
    .Write_data (Write_data),
    .Rd         (Rd),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // kind: 0 = multiply, 1 = iterative divide, 2 = divide corner case (DONE at E1).
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_wd,
                        input int kind, input bit poke);
    int edges;
    int pulses;
    int rw_edge;
    int exp_busy;
    int exp_rw;
    @(negedge clk);
    Funct3 = f3; Read_data1 = a; Read_data2 = b; Rd_in = rd; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0; Read_data1 = ~a; Read_data2 = ~b; Rd_in = ~rd; Funct3 = ~f3;
    edges = 0; pulses = 0; rw_edge = -1;
    if (RegWrite) begin pulses++; rw_edge = 0; end
    while (Busy && edges < 100) begin
      if (poke && edges == 4) begin
        Start = 1'b1; Funct3 = 3'b101; Read_data1 = 32'd3; Read_data2 = 32'd1; Rd_in = 5'd1;
      end else if (poke && RegWrite) begin
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
      if (RegWrite) begin pulses++; rw_edge = edges; end
    end
    Start = 1'b0;
    if (kind == 2) begin
      exp_busy = 2; exp_rw = 1;
    end else if (kind == 0 && FAST_MUL) begin
      exp_busy = 1; exp_rw = 0;
    end else begin
      exp_busy = 33; exp_rw = 32;
    end
    check({tag, "_busy_cycles"}, edges, exp_busy);
    check({tag, "_wdata"}, Write_data, exp_wd);
    check({tag, "_rd"}, {27'd0, Rd}, {27'd0, rd});
    check({tag, "_pulses"}, pulses, (rd != 5'd0) ? 32'd1 : 32'd0);
    if (rd != 5'd0) begin
      check({tag, "_rw_edge"}, rw_edge, exp_rw);
    end
  endtask

  initial begin : stim
    int pulses;
    reset = 1'b0; Start = 1'b0; Funct3 = 3'd0; Read_data1 = 32'd0; Read_data2 = 32'd0; Rd_in = 5'd0;
    #2 reset = 1'b1;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_wdata", Write_data, 32'd0);
    check("rst_rd", {27'd0, Rd}, 32'd0);
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       0, 1'b0);
    run_op("mulh_m1x2",    3'b001, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, 0, 1'b0);
    run_op("mulhsu_m1x2",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF, 0, 1'b0);
    run_op("mulhu_m1x2",   3'b011, 32'hFFFFFFFF, 32'd2,        5'd8,  32'h00000001, 0, 1'b0);
    run_op("mul_m1x2",     3'b000, 32'hFFFFFFFF, 32'd2,        5'd9,  32'hFFFFFFFE, 0, 1'b0);
    run_op("mulh_min_sq",  3'b001, 32'h80000000, 32'h80000000, 5'd10, 32'h40000000, 0, 1'b0);
    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 1, 1'b0);
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, 1, 1'b0);
    run_op("divu_20_3",    3'b101, 32'd20,       32'd3,        5'd13, 32'd6,        1, 1'b0);
    run_op("remu_20_3",    3'b111, 32'd20,       32'd3,        5'd14, 32'd2,        1, 1'b0);
    run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 1, 1'b0);
    run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        1, 1'b0);
    run_op("div_by0",      3'b100, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 2, 1'b0);
    run_op("rem_by0",      3'b110, 32'd5,        32'd0,        5'd18, 32'd5,        2, 1'b0);
    run_op("divu_by0",     3'b101, 32'd9,        32'd0,        5'd19, 32'hFFFFFFFF, 2, 1'b0);
    run_op("remu_by0",     3'b111, 32'd9,        32'd0,        5'd20, 32'd9,        2, 1'b0);
    run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 2, 1'b0);
    run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,        2, 1'b0);
    run_op("divu_rd0",     3'b101, 32'd100,      32'd7,        5'd0,  32'd14,       1, 1'b0);
    run_op("divu_poke",    3'b101, 32'd1000,     32'd10,       5'd9,  32'd100,      1, 1'b1);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    Funct3 = 3'b100; Read_data1 = 32'd100; Read_data2 = 32'd7; Rd_in = 5'd3; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check("mid_busy_pre", {31'd0, Busy}, 32'd1);
    check("mid_rd_pre", {27'd0, Rd}, 32'd3);
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("arst_wdata", Write_data, 32'd0);
    check("arst_rd", {27'd0, Rd}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (RegWrite) pulses++;
    end
    check("arst_no_wb", pulses, 32'd0);
    run_op("mul_after_rst", 3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
